// File: rtl/mult_cdb_stage.sv
// Completion stage behind the fixed-latency multiplier. A sideband pipe carries
// each issued op's destination tag and ROB index in step with the multiplier,
// results are captured into a small FIFO, and the FIFO head bids for the CDB.
// Issue is credit-limited so the FIFO can never overflow.
module mult_cdb_stage #(
  parameter int XLEN      = 32,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int MULT_LAT  = 2,
  parameter int QDEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_flush,
  input  logic                 issue_valid,
  input  logic [PRF_IDX_W-1:0] issue_dest_tag,
  input  logic [ROB_IDX_W-1:0] issue_rob_idx,
  output logic                 issue_ready,
  input  logic [XLEN-1:0]      mult_result,
  output logic                 cdb_req,
  input  logic                 cdb_gnt,
  output logic [PRF_IDX_W-1:0] cdb_tag,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [XLEN-1:0]      cdb_value
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  // Sideband pipe, one stage per multiplier cycle
  logic                 sb_vld_q [MULT_LAT];
  logic [PRF_IDX_W-1:0] sb_tag_q [MULT_LAT];
  logic [ROB_IDX_W-1:0] sb_rob_q [MULT_LAT];

  // Completion FIFO storage (no reset; validity is tracked by count_q)
  logic [PRF_IDX_W-1:0] fifo_tag_q [QDEPTH];
  logic [ROB_IDX_W-1:0] fifo_rob_q [QDEPTH];
  logic [XLEN-1:0]      fifo_val_q [QDEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inflight;

  logic issue_fire;
  logic capture;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign issue_fire = issue_valid && issue_ready;
  assign capture    = sb_vld_q[MULT_LAT-1];
  assign cdb_req    = (count_q != '0);
  assign pop        = cdb_req && cdb_gnt;

  genvar gi;
  generate
    for (gi = 0; gi < MULT_LAT; gi++) begin : g_sb
      if (gi == 0) begin : g_head
        // First stage takes the op accepted this cycle; flush drops it
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sb_vld_q[gi] <= 1'b0;
            sb_tag_q[gi] <= '0;
            sb_rob_q[gi] <= '0;
          end else begin
            sb_vld_q[gi] <= issue_fire && !pipe_flush;
            sb_tag_q[gi] <= issue_dest_tag;
            sb_rob_q[gi] <= issue_rob_idx;
          end
        end
      end else begin : g_tail
        // Later stages shift unconditionally, matching the non-stalling multiplier
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sb_vld_q[gi] <= 1'b0;
            sb_tag_q[gi] <= '0;
            sb_rob_q[gi] <= '0;
          end else begin
            sb_vld_q[gi] <= sb_vld_q[gi-1] && !pipe_flush;
            sb_tag_q[gi] <= sb_tag_q[gi-1];
            sb_rob_q[gi] <= sb_rob_q[gi-1];
          end
        end
      end
    end
  endgenerate

  // Number of ops still travelling through the multiplier
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MULT_LAT; i++) begin
      inflight = inflight + CNT_W'(sb_vld_q[i]);
    end
  end

  // Credit check from registered state only, so cdb_gnt never reaches issue_ready
  assign issue_ready = ({1'b0, count_q} + {1'b0, inflight}) < SUM_W'(QDEPTH);

  // FIFO pointer/count next state; flush overrides any push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pipe_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (capture) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({capture, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write the completing op into the tail slot
  always_ff @(posedge clk) begin
    if (capture && !pipe_flush) begin
      fifo_tag_q[wr_ptr_q] <= sb_tag_q[MULT_LAT-1];
      fifo_rob_q[wr_ptr_q] <= sb_rob_q[MULT_LAT-1];
      fifo_val_q[wr_ptr_q] <= mult_result;
    end
  end

  // Head is shown only while valid, so an empty FIFO drives zeros
  assign cdb_tag     = cdb_req ? fifo_tag_q[rd_ptr_q] : '0;
  assign cdb_rob_idx = cdb_req ? fifo_rob_q[rd_ptr_q] : '0;
  assign cdb_value   = cdb_req ? fifo_val_q[rd_ptr_q] : '0;

`ifndef SYNTHESIS
  // Upstream must not issue once credit is exhausted
  a_no_issue_without_credit: assert property (
    @(posedge clk) disable iff (!rst_n) !(issue_valid && !issue_ready)
  ) else $error("issue_valid asserted while issue_ready=0");
`endif

endmodule

// File: tb/tb_mult_cdb_stage.sv
// Directed bench for mult_cdb_stage: a cycle table for single-op, back-pressure
// and flush, then scripted runs for FIFO wrap, head stall and async reset.
module tb_mult_cdb_stage;

  localparam int XLEN = 32;
  localparam int PRF  = 6;
  localparam int ROB  = 5;
  localparam int LAT  = 2;
  localparam int QD   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pipe_flush = 1'b0;
  logic            issue_valid = 1'b0;
  logic [PRF-1:0]  issue_dest_tag = '0;
  logic [ROB-1:0]  issue_rob_idx = '0;
  logic            issue_ready;
  logic [XLEN-1:0] mult_result = '0;
  logic            cdb_req;
  logic            cdb_gnt = 1'b0;
  logic [PRF-1:0]  cdb_tag;
  logic [ROB-1:0]  cdb_rob_idx;
  logic [XLEN-1:0] cdb_value;

  always #5 clk = ~clk;

  mult_cdb_stage #(
    .XLEN(XLEN), .PRF_IDX_W(PRF), .ROB_IDX_W(ROB), .MULT_LAT(LAT), .QDEPTH(QD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .issue_valid(issue_valid), .issue_dest_tag(issue_dest_tag),
    .issue_rob_idx(issue_rob_idx), .issue_ready(issue_ready),
    .mult_result(mult_result), .cdb_req(cdb_req), .cdb_gnt(cdb_gnt),
    .cdb_tag(cdb_tag), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic        iv;
    logic [5:0]  tag;
    logic [4:0]  rob;
    logic [31:0] res;
    logic        gnt;
    logic        fl;
    logic        e_rdy;
    logic        e_req;
    logic [5:0]  e_tag;
    logic [4:0]  e_rob;
    logic [31:0] e_val;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [5:0] tag, input logic [4:0] rob,
                     input logic [31:0] res, input logic gnt, input logic fl,
                     input logic e_rdy, input logic e_req, input logic [5:0] e_tag,
                     input logic [4:0] e_rob, input logic [31:0] e_val);
    vec_t v;
    v.iv = iv; v.tag = tag; v.rob = rob; v.res = res; v.gnt = gnt; v.fl = fl;
    v.e_rdy = e_rdy; v.e_req = e_req; v.e_tag = e_tag; v.e_rob = e_rob; v.e_val = e_val;
    vecs.push_back(v);
  endtask

  // ---------------- scripted-run model ----------------
  typedef struct {
    logic [5:0]  tag;
    logic [4:0]  rob;
    logic [31:0] val;
    int          icyc;
  } op_t;

  op_t         sbq[$];
  logic [31:0] res_by_cyc [256];
  int          sc_cyc, sc_k, sc_out, sc_pops;
  logic [5:0]  sc_base;

  task automatic sc_init(input logic [5:0] base);
    sc_cyc = 0; sc_k = 0; sc_out = 0; sc_pops = 0; sc_base = base;
    sbq.delete();
    for (int i = 0; i < 256; i++) res_by_cyc[i] = 32'hDEAD_BEEF;
  endtask

  // One clock of a scripted run: drive, check against the model, advance
  task automatic sc_cycle(input bit want, input bit gnt, input int max_ops);
    bit          exp_req, do_issue;
    logic [5:0]  t;
    logic [4:0]  r;
    logic [31:0] v;
    op_t         o;
    exp_req  = (sbq.size() > 0) && (sbq[0].icyc + LAT + 1 <= sc_cyc);
    do_issue = want && (sc_k < max_ops) && (sc_out < QD);
    t = sc_base + 6'(sc_k);
    r = 5'(10 + sc_k);
    v = {16'hC0DE, 2'b00, sc_base, 8'(sc_k)};
    issue_valid    = do_issue;
    issue_dest_tag = t;
    issue_rob_idx  = r;
    mult_result    = res_by_cyc[sc_cyc];
    cdb_gnt        = gnt;
    pipe_flush     = 1'b0;
    #1;
    chk($sformatf("sc%0d_ready", sc_cyc), 32'(issue_ready), 32'(sc_out < QD));
    chk($sformatf("sc%0d_req", sc_cyc), 32'(cdb_req), 32'(exp_req));
    if (exp_req) begin
      chk($sformatf("sc%0d_tag", sc_cyc), 32'(cdb_tag), 32'(sbq[0].tag));
      chk($sformatf("sc%0d_rob", sc_cyc), 32'(cdb_rob_idx), 32'(sbq[0].rob));
      chk($sformatf("sc%0d_val", sc_cyc), cdb_value, sbq[0].val);
      if (gnt) begin
        $display("cyc %0d pop tag=%0d rob=%0d val=%h", sc_cyc, cdb_tag, cdb_rob_idx, cdb_value);
        void'(sbq.pop_front());
        sc_out--;
        sc_pops++;
      end
    end
    if (do_issue) begin
      o.tag = t; o.rob = r; o.val = v; o.icyc = sc_cyc;
      sbq.push_back(o);
      res_by_cyc[sc_cyc + LAT] = v;
      sc_out++;
      sc_k++;
    end
    @(posedge clk); #1;
    sc_cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single op: tag5 rob3 issued c0, result c2, broadcast c3
    add(1, 5, 3, 32'h0,    1, 0,  1, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,    1, 0,  1, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h1234, 1, 0,  1, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,    1, 0,  1, 1, 5, 3, 32'h1234);
    add(0, 0, 0, 32'h0,    1, 0,  1, 0, 0, 0, 32'h0);
    // Back-pressure: four issues with no grant, then drain in order
    add(1, 10, 1, 32'h0,  0, 0,  1, 0, 0,  0, 32'h0);
    add(1, 11, 2, 32'h0,  0, 0,  1, 0, 0,  0, 32'h0);
    add(1, 12, 3, 32'hA0, 0, 0,  1, 0, 0,  0, 32'h0);
    add(1, 13, 4, 32'hB0, 0, 0,  1, 1, 10, 1, 32'hA0);
    add(0, 0,  0, 32'hC0, 0, 0,  0, 1, 10, 1, 32'hA0);
    add(0, 0,  0, 32'hD0, 0, 0,  0, 1, 10, 1, 32'hA0);
    add(0, 0,  0, 32'h0,  1, 0,  0, 1, 10, 1, 32'hA0);
    add(0, 0,  0, 32'h0,  1, 0,  1, 1, 11, 2, 32'hB0);
    add(0, 0,  0, 32'h0,  1, 0,  1, 1, 12, 3, 32'hC0);
    add(0, 0,  0, 32'h0,  1, 0,  1, 1, 13, 4, 32'hD0);
    add(0, 0,  0, 32'h0,  0, 0,  1, 0, 0,  0, 32'h0);
    // Flush with two buffered and two in flight
    add(1, 20, 5, 32'h0,  0, 0,  1, 0, 0,  0, 32'h0);
    add(1, 21, 6, 32'h0,  0, 0,  1, 0, 0,  0, 32'h0);
    add(1, 22, 7, 32'hE0, 0, 0,  1, 0, 0,  0, 32'h0);
    add(1, 23, 8, 32'hF0, 0, 0,  1, 1, 20, 5, 32'hE0);
    add(0, 0,  0, 32'h60, 0, 1,  0, 1, 20, 5, 32'hE0);
    add(0, 0,  0, 32'h70, 0, 0,  1, 0, 0,  0, 32'h0);
    add(0, 0,  0, 32'h0,  1, 0,  1, 0, 0,  0, 32'h0);
    add(0, 0,  0, 32'h0,  0, 0,  1, 0, 0,  0, 32'h0);
    add(0, 0,  0, 32'h0,  1, 0,  1, 0, 0,  0, 32'h0);

    // Reset, released away from a clock edge
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      issue_valid    = vecs[i].iv;
      issue_dest_tag = vecs[i].tag;
      issue_rob_idx  = vecs[i].rob;
      mult_result    = vecs[i].res;
      cdb_gnt        = vecs[i].gnt;
      pipe_flush     = vecs[i].fl;
      #1;
      $display("vec %0d ready=%0b req=%0b tag=%0d rob=%0d val=%h",
               i, issue_ready, cdb_req, cdb_tag, cdb_rob_idx, cdb_value);
      chk($sformatf("row%0d_ready", i), 32'(issue_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("row%0d_req", i), 32'(cdb_req), 32'(vecs[i].e_req));
      chk($sformatf("row%0d_tag", i), 32'(cdb_tag), 32'(vecs[i].e_tag));
      chk($sformatf("row%0d_rob", i), 32'(cdb_rob_idx), 32'(vecs[i].e_rob));
      chk($sformatf("row%0d_val", i), cdb_value, vecs[i].e_val);
      @(posedge clk); #1;
    end
    pipe_flush = 1'b0;

    // Ten ops through a depth-4 FIFO; grant lands on the capture cycle at c5
    sc_init(6'd32);
    for (int c = 0; c < 80 && sc_pops < 10; c++) begin
      sc_cycle(1'b1, (c == 5) || (c >= 8 && (c % 3) != 0) || (c >= 30), 10);
    end
    chk("wrap_pops", 32'(sc_pops), 32'd10);
    for (int c = 0; c < 3; c++) sc_cycle(1'b0, 1'b1, 10);

    // Head tag 9 held for six ungranted cycles
    sc_init(6'd9);
    sc_cycle(1'b1, 1'b0, 1);
    for (int c = 0; c < 8; c++) sc_cycle(1'b0, 1'b0, 1);
    for (int c = 0; c < 2; c++) sc_cycle(1'b0, 1'b1, 1);
    chk("stall_pops", 32'(sc_pops), 32'd1);

    // Async reset mid-stream, asserted between clock edges
    sc_init(6'd40);
    sc_cycle(1'b1, 1'b0, 2);
    sc_cycle(1'b1, 1'b0, 2);
    sc_cycle(1'b0, 1'b0, 2);
    sc_cycle(1'b0, 1'b0, 2);
    chk("pre_rst_req", 32'(cdb_req), 32'd1);
    #3;
    issue_valid = 1'b0;
    cdb_gnt     = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("arst_req", 32'(cdb_req), 32'd0);
    chk("arst_ready", 32'(issue_ready), 32'd1);
    chk("arst_tag", 32'(cdb_tag), 32'd0);
    chk("arst_rob", 32'(cdb_rob_idx), 32'd0);
    chk("arst_val", cdb_value, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    sc_init(6'd50);
    sc_cycle(1'b1, 1'b1, 1);
    for (int c = 0; c < 6; c++) sc_cycle(1'b0, 1'b1, 1);
    chk("post_rst_pops", 32'(sc_pops), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_cdb_stage.md
Name: mult_cdb_stage

Overview:
- Completion stage directly downstream of the multiplier unit.
- Carries each issued multiply's destination physical tag and ROB index alongside the fixed-latency multiplier datapath.
- Captures the multiplier result at the correct cycle and buffers completed results in a small FIFO.
- Arbitrates for the common data bus (CDB) with a req/gnt handshake, and back-pressures multiply issue through a credit-based ready.

Parameters:
- XLEN, 32, datapath width of the multiplier result.
- PRF_IDX_W, 6, physical register tag width.
- ROB_IDX_W, 5, ROB index width.
- MULT_LAT, 2, cycles from issue to a valid multiplier result; legal range 1..4.
- QDEPTH, 4, completion FIFO depth; power of two, must be >= MULT_LAT.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- pipe_flush  in  1  synchronous squash of all in-flight and buffered ops
- issue_valid  in  1  multiply issued to the multiplier this cycle
- issue_dest_tag  in  PRF_IDX_W  destination physical register of the issued op
- issue_rob_idx  in  ROB_IDX_W  ROB entry of the issued op
- issue_ready  out  1  issue permitted this cycle
- mult_result  in  XLEN  multiplier output; meaningful exactly MULT_LAT cycles after its issue
- cdb_req  out  1  buffered result available for broadcast
- cdb_gnt  in  1  CDB arbiter grant for this unit
- cdb_tag  out  PRF_IDX_W  tag of the FIFO head
- cdb_rob_idx  out  ROB_IDX_W  ROB index of the FIFO head
- cdb_value  out  XLEN  result of the FIFO head

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All state clears on reset: sideband valid bits, FIFO pointers, count, in-flight counter.
  - Outputs after reset: cdb_req=0, cdb_tag=0, cdb_rob_idx=0, cdb_value=0, issue_ready=1.
- Sideband pipe: MULT_LAT-entry shift register of {valid, dest_tag, rob_idx}.
  - Stage 0 loads issue_valid && issue_ready.
  - Advances every cycle, with no stall, because the multiplier itself never stalls.
- Capture: when the last sideband stage is valid, {tag, rob_idx, mult_result} is written to the FIFO tail at the clock edge.
- Latency: issue at cycle N gives mult_result at cycle N+MULT_LAT and cdb_req=1 at cycle N+MULT_LAT+1. There is no FIFO bypass.
- CDB handshake:
  - cdb_req = FIFO non-empty; cdb_tag, cdb_rob_idx and cdb_value show the head entry combinationally.
  - Pop happens when cdb_req && cdb_gnt.
  - The head must hold stable while cdb_req=1 && cdb_gnt=0.
  - cdb_gnt while cdb_req=0 is ignored.
- Credit:
  - inflight = count of valid sideband stages.
  - issue_ready = (fifo_count + inflight) < QDEPTH, computed from registered state only, with no combinational path from cdb_gnt.
  - issue_valid while issue_ready=0 is dropped. Asserting it is an upstream protocol error; a simulation assertion flags it.
  - The FIFO therefore never overflows. A push and a pop in the same cycle leave the count unchanged, including when the FIFO is full.
- Pointers: wr_ptr and rd_ptr are log2(QDEPTH) bits, wrap modulo QDEPTH, and a separate count runs 0..QDEPTH.
- pipe_flush (highest priority after reset):
  - Clears all sideband valids, the FIFO, and the counters at the next edge.
  - A concurrent issue, capture or pop in that cycle is discarded.
  - cdb_req=0 the cycle after the flush.
  - The multiplier flushes itself; no result from a pre-flush op reaches the CDB.
- Reset asserted mid-operation: immediate clear of all state, whatever the FIFO or pipe contents.

Test Plan:
- Single op: at cycle 0 issue tag=5, rob=3; drive mult_result=0x0000_1234 at cycle 2; cdb_gnt=1 → cdb_req=1 at cycle 3 with tag=5, rob=3, value=0x1234. cdb_req=0 at cycle 4.
- Back-pressure: cdb_gnt=0, issue on 4 consecutive cycles → issue_ready=0 from the cycle after the 4th issue. Raise cdb_gnt for 1 cycle → issue_ready returns to 1 on the next cycle and the results pop in issue order.
- Full with simultaneous push/pop: 3 entries buffered plus 1 in flight and cdb_gnt=1 on the capture cycle → count stays 4; no data lost or duplicated; head order preserved across the wr_ptr/rd_ptr wrap (send 10 ops total).
- Stall hold: head tag=9 with cdb_gnt=0 for 5 cycles → cdb_tag, cdb_rob_idx and cdb_value stay constant and cdb_req stays 1 throughout.
- Flush: 2 ops buffered and 2 in flight, pipe_flush for 1 cycle → cdb_req=0 the next cycle; no further cdb_req for those ops; issue_ready=1.
- Async reset: assert rst_n=0 mid-stream, off a clock edge → outputs go to reset values immediately; after release the first new op completes with the normal MULT_LAT+1 latency.
